// File: rtl/serial_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : serial_tx_pkg                                              |
// | Desc    : State encodings, line levels and width helper for the      |
// |           serial_frame_tx block.                                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package serial_tx_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_START  = 3'd1;
  localparam logic [STATE_W-1:0] S_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] S_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] S_STOP   = 3'd4;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // A count range of 1 still needs a 1-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bit_timer                                                  |
// | Desc    : Free-running bit-period counter 0..CLKS_PER_BIT-1; tick in |
// |           the last clock of each bit, held at zero while run=0.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bit_timer
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick,
  output logic tick_next
);

  localparam int                CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == LAST);

  // tick_next: the next clock is the last of a bit, assuming run stays high.
  generate
    if (CLKS_PER_BIT == 1) begin : g_single
      assign tick_next = 1'b1;
    end else begin : g_multi
      assign tick_next = run && (cnt_q == CNT_W'(CLKS_PER_BIT - 2));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_frame_tx                                            |
// | Desc    : Serialises a parallel word as start/data/[parity]/stop     |
// |           with valid/ready input and a frame_done pulse.             |
// |           Macro SERIAL_FRAME_TX_PARITY_EN adds an even parity bit.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_msb_first,
  output logic              ser_out,
  output logic              ser_active,
  output logic              frame_done
);

  localparam int               IDX_W    = cnt_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               msb_first_q, msb_first_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               ser_out_q, ser_out_d;
  logic               in_ready_q, in_ready_d;
  logic               ser_active_q, ser_active_d;
  logic               frame_done_q, frame_done_d;

  logic               tick;
  logic               tick_next;
  logic               accept;
  logic [IDX_W-1:0]   sel_idx;

  assign accept = in_valid && in_ready_q;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state_q != S_IDLE),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      msb_first_q  <= 1'b0;
      bit_idx_q    <= '0;
      ser_out_q    <= IDLE_LEVEL;
      in_ready_q   <= 1'b1;
      ser_active_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      msb_first_q  <= msb_first_d;
      bit_idx_q    <= bit_idx_d;
      ser_out_q    <= ser_out_d;
      in_ready_q   <= in_ready_d;
      ser_active_q <= ser_active_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    msb_first_d = msb_first_q;
    bit_idx_d   = bit_idx_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_START;
          data_d      = in_data;
          msb_first_d = in_msb_first;
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        bit_idx_d = '0;
      end
    endcase
  end

  // Outputs are computed from next-state values so the registered line
  // switches exactly on bit boundaries with no extra cycle of latency.
  assign sel_idx = msb_first_d ? (LAST_IDX - bit_idx_d) : bit_idx_d;

  always_comb begin
    ser_out_d    = IDLE_LEVEL;
    in_ready_d   = (state_d == S_IDLE);
    ser_active_d = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP) && tick_next;
    case (state_d)
      S_START:  ser_out_d = START_BIT;
      S_DATA:   ser_out_d = data_d[sel_idx];
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: ser_out_d = ^data_d;
`endif
      S_STOP:   ser_out_d = STOP_BIT;
      default:  ser_out_d = IDLE_LEVEL;
    endcase
  end

  assign in_ready   = in_ready_q;
  assign ser_out    = ser_out_q;
  assign ser_active = ser_active_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_serial_frame_tx                                         |
// | Desc    : Directed table-driven bench for serial_frame_tx            |
// |           (CLKS_PER_BIT=4 and CLKS_PER_BIT=1 instances).             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 18 + PAR;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid, in_msb, in_ready, ser_out, ser_active, frame_done;
  logic [15:0] in_data [2];

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(16), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_msb_first(in_msb[0]), .ser_out(ser_out[0]),
    .ser_active(ser_active[0]), .frame_done(frame_done[0])
  );

  serial_frame_tx #(.DATA_W(16), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_msb_first(in_msb[1]), .ser_out(ser_out[1]),
    .ser_active(ser_active[1]), .frame_done(frame_done[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] data;
    logic        msb;
    logic [15:0] seq;   // data bits in transmission order, first bit at [15]
    logic        par;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ready(input int sel);
    int n = 0;
    while (in_ready[sel] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready[sel] !== 1'b1) chk("ready_timeout", 32'(in_ready[sel]), 32'd1);
  endtask

  task automatic check_frame(input int sel, input int cpb, input logic [15:0] seq,
                             input logic par, input string nm);
    int   flen;
    int   k;
    logic eb;
    flen = NBITS * cpb;
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)                   eb = 1'b0;
      else if (b <= 16)             eb = seq[16-b];
      else if (PAR == 1 && b == 17) eb = par;
      else                          eb = 1'b1;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        k = b * cpb + c + 1;
        chk($sformatf("%s_ser_k%0d", nm, k), 32'(ser_out[sel]), 32'(eb));
        chk($sformatf("%s_act_k%0d", nm, k), 32'(ser_active[sel]), 32'd1);
        chk($sformatf("%s_rdy_k%0d", nm, k), 32'(in_ready[sel]), 32'd0);
        chk($sformatf("%s_done_k%0d", nm, k), 32'(frame_done[sel]), 32'(k == flen));
      end
    end
  endtask

  task automatic check_idle(input int sel, input string nm);
    chk({nm, "_ser"},  32'(ser_out[sel]),    32'd1);
    chk({nm, "_rdy"},  32'(in_ready[sel]),   32'd1);
    chk({nm, "_act"},  32'(ser_active[sel]), 32'd0);
    chk({nm, "_done"}, 32'(frame_done[sel]), 32'd0);
  endtask

  task automatic send(input int sel, input int cpb, input logic [15:0] d, input logic msb,
                      input logic [15:0] seq, input logic par, input string nm);
    @(negedge clk);
    wait_ready(sel);
    in_valid[sel] = 1'b1;
    in_data[sel]  = d;
    in_msb[sel]   = msb;
    @(posedge clk);
    #1 in_valid[sel] = 1'b0;
    check_frame(sel, cpb, seq, par, nm);
    @(negedge clk);
    check_idle(sel, {nm, "_after"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    logic saw_low;

    vecs[0] = '{data: 16'hA5C3, msb: 1'b1, seq: 16'hA5C3, par: 1'b0};
    vecs[1] = '{data: 16'hA5C3, msb: 1'b0, seq: 16'hC3A5, par: 1'b0};
    vecs[2] = '{data: 16'h0001, msb: 1'b1, seq: 16'h0001, par: 1'b1};
    vecs[3] = '{data: 16'h0001, msb: 1'b0, seq: 16'h8000, par: 1'b1};
    vecs[4] = '{data: 16'hFFFF, msb: 1'b1, seq: 16'hFFFF, par: 1'b0};
    vecs[5] = '{data: 16'h1234, msb: 1'b0, seq: 16'h2C48, par: 1'b1};

    rst_n    = 1'b0;
    in_valid = '0;
    in_msb   = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(0, 4, vecs[i].data, vecs[i].msb, vecs[i].seq, vecs[i].par, $sformatf("vec%0d", i));
    end

    // Two words queued with in_valid held high across both frames.
    @(negedge clk);
    wait_ready(0);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'hA5C3;
    in_msb[0]   = 1'b1;
    @(posedge clk);
    #1 in_data[0] = 16'h0001;
    check_frame(0, 4, 16'hA5C3, 1'b0, "b2b_first");
    @(negedge clk);
    check_idle(0, "b2b_gap");
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    check_frame(0, 4, 16'h0001, 1'b1, "b2b_second");
    @(negedge clk);
    check_idle(0, "b2b_after");

    // Reset while data bit 7 (clocks 33..36 after accept) is on the line.
    @(negedge clk);
    wait_ready(0);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'hA5C3;
    in_msb[0]   = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (34) @(negedge clk);
    chk("abort_bit7", 32'(ser_out[0]), 32'd1);
    chk("abort_active", 32'(ser_active[0]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle(0, "abort");
    rst_n = 1'b1;
    seen_done = 1'b0;
    saw_low   = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      seen_done = seen_done | frame_done[0];
      saw_low   = saw_low | ~ser_out[0];
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_line_high", 32'(saw_low), 32'd0);
    send(0, 4, 16'hA5C3, 1'b1, 16'hA5C3, 1'b0, "post_abort");

    // One clock per bit.
    send(1, 1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, "cpb1_ffff");
    send(1, 1, 16'hA5C3, 1'b0, 16'hC3A5, 1'b0, "cpb1_a5c3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
